// File: rtl/mips_pkg.sv
// mips_pkg: shared multiply/divide op encodings, FSM states and iteration count
package mips_pkg;
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_RUN  = 2'b10,
    S_FIX  = 2'b11
  } md_state_t;
  localparam int STEPS = 32;
endpackage

// File: rtl/md_sign_fixup.sv
// md_sign_fixup: turns the unsigned magnitude result into signed HI/LO (raw result, op, operand signs, div-by-zero in; hi/lo out)
module md_sign_fixup
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] raw,
  input  md_op_t             op,
  input  logic               sa,
  input  logic               sb,
  input  logic               dbz,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);
  logic [2*WIDTH-1:0] prod;
  logic               is_div;
  always_comb begin
    is_div = (op == MD_DIV) || (op == MD_DIVU);
    prod   = (sa ^ sb) ? -raw : raw;
    // remainder follows the dividend sign, which also restores HI=A on divide by zero
    hi     = is_div ? (sa ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
    // divide by zero keeps the all-ones quotient regardless of signs
    lo     = is_div ? (((sa ^ sb) && !dbz) ? -raw[WIDTH-1:0] : raw[WIDTH-1:0]) : prod[WIDTH-1:0];
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: 32-step sequential MULT/MULTU/DIV/DIVU with HI/LO (start/MDOp/A/B in; Busy/Done/DivByZero/HI/LO out)
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = $clog2(WIDTH);
  md_state_t          state, state_n;
  md_op_t             op;
  logic               sa, sb, dbz, sgn, is_div, ge;
  logic [WIDTH-1:0]   ma, mb, rnext, fhi, flo;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     msum, rem;
  assign sgn    = ~MDOp[0];
  assign is_div = (op == MD_DIV) || (op == MD_DIVU);
  assign Busy   = state != S_IDLE;
  always_comb begin
    msum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mb[0] ? {1'b0, ma} : '0);
    // partial remainder with the next dividend bit shifted in; may need WIDTH+1 bits
    rem   = {acc[2*WIDTH-1:WIDTH], ma[WIDTH-1]};
    ge    = rem >= {1'b0, mb};
    rnext = ge ? WIDTH'(rem - {1'b0, mb}) : rem[WIDTH-1:0];
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = start ? S_PREP : S_IDLE;
      S_PREP:  state_n = S_RUN;
      S_RUN:   state_n = (cnt == '0) ? S_FIX : S_RUN;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_n;
  md_sign_fixup #(.WIDTH(WIDTH)) u_fix (
    .raw(acc), .op(op), .sa(sa), .sb(sb), .dbz(dbz), .hi(fhi), .lo(flo)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op        <= MD_MULT;
      sa        <= 1'b0;
      sb        <= 1'b0;
      dbz       <= 1'b0;
      ma        <= '0;
      mb        <= '0;
      acc       <= '0;
      cnt       <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      HI        <= '0;
      LO        <= '0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          op  <= md_op_t'(MDOp);
          sa  <= sgn & A[WIDTH-1];
          sb  <= sgn & B[WIDTH-1];
          ma  <= (sgn & A[WIDTH-1]) ? -A : A;
          mb  <= (sgn & B[WIDTH-1]) ? -B : B;
          dbz <= B == '0;
        end
        S_PREP: begin
          acc <= '0;
          cnt <= CW'(WIDTH - 1);
        end
        S_RUN: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            acc <= {rnext, acc[WIDTH-2:0], ge};
            ma  <= ma << 1;
          end else begin
            acc <= {msum, acc[WIDTH-1:1]};
            mb  <= mb >> 1;
          end
        end
        default: begin
          HI        <= fhi;
          LO        <= flo;
          Done      <= 1'b1;
          DivByZero <= dbz & is_div;
        end
      endcase
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors plus a cycle-timeline model checked every cycle
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  MDOp = 2'b00;
  logic [31:0] A = '0, B = '0;
  logic        Busy, Done, DivByZero;
  logic [31:0] HI, LO;
  int total = 0, passed = 0;
  bit chk_en = 1'b0;
  int cyc, done_at;
  bit mbusy, exp_done, exp_dbz, pend_dbz;
  logic [31:0] exp_hi, exp_lo, pend_hi, pend_lo;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .MDOp(MDOp), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sl_a, sl_b;
    logic [63:0] p;
    int ia, ib;
    sl_a = $signed(a);
    sl_b = $signed(b);
    ia = a;
    ib = b;
    case (op)
      2'b00: begin p = sl_a * sl_b; return {1'b0, p}; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
        return {1'b0, 32'(ia % ib), 32'(ia / ib)};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // timeline model: accepted start at edge k -> busy until edge k+34, results and pulse at k+34
  always @(posedge clk or posedge reset) begin
    logic [64:0] r;
    if (reset) begin
      cyc = 0; mbusy = 0; exp_done = 0; exp_dbz = 0; exp_hi = 0; exp_lo = 0;
    end else begin
      cyc++;
      exp_done = 0;
      exp_dbz = 0;
      if (mbusy && cyc == done_at) begin
        exp_hi = pend_hi; exp_lo = pend_lo; exp_dbz = pend_dbz; exp_done = 1; mbusy = 0;
      end else if (!mbusy && start) begin
        r = model(MDOp, A, B);
        {pend_dbz, pend_hi, pend_lo} = r;
        pend_dbz = pend_dbz & MDOp[1];
        mbusy = 1;
        done_at = cyc + 34;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("busy", 64'(Busy), 64'(mbusy));
    check("done", 64'(Done), 64'(exp_done));
    check("dbz", 64'(DivByZero), 64'(exp_dbz));
    check("hi", 64'(HI), 64'(exp_hi));
    check("lo", 64'(LO), 64'(exp_lo));
  end

  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input bit edbz, input int intr);
    int n, nb;
    start = 1; MDOp = op; A = a; B = b;
    @(negedge clk);
    start = 0; A = $urandom; B = $urandom; MDOp = 2'($urandom);
    n = 0; nb = 0;
    while (!Done && n < 40) begin
      if (Busy) nb++;
      start = (n == intr);
      @(negedge clk);
      n++;
    end
    start = 0;
    check({name, "_latency"}, 64'(n), 64'd34);
    check({name, "_busycycles"}, 64'(nb), 64'd34);
    check({name, "_HI"}, 64'(HI), 64'(ehi));
    check({name, "_LO"}, 64'(LO), 64'(elo));
    check({name, "_DivByZero"}, 64'(DivByZero), 64'(edbz));
  endtask

  initial begin
    int nd;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_hi", 64'(HI), 64'd0);
    check("reset_lo", 64'(LO), 64'd0);
    reset = 0;
    chk_en = 1;
    @(negedge clk);
    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, -1);
    repeat (2) @(negedge clk);
    do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, -1);
    do_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0, -1);
    do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, -1);
    do_op("div_negb", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0, -1);
    do_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0, -1);
    do_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1, -1);
    do_op("div_zero_neg", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1, -1);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, -1);
    do_op("ignore_start", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 0, 5);
    do_op("back2back", 2'b11, 32'd1000, 32'd10, 32'd0, 32'd100, 0, -1);
    do_op("preload", 2'b11, 32'h5678_1234, 32'h0001_0000, 32'h1234, 32'h5678, 0, -1);
    start = 1; MDOp = 2'b00; A = 32'd3; B = 32'd5;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    #2 reset = 1;
    #1;
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_hi", 64'(HI), 64'd0);
    check("abort_lo", 64'(LO), 64'd0);
    check("abort_done", 64'(Done), 64'd0);
    @(negedge clk);
    reset = 0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) nd++;
    end
    check("abort_no_done", 64'(nd), 64'd0);
    check("abort_idle", 64'(Busy), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
